// File: rtl/jpeg_out_packer.sv
// Packs the JPEG encoder's byte stream big-endian into 32-bit words and buffers them
// in a first-word fall-through FIFO; the EOI marker (FF D9) closes and flushes a frame.
module jpeg_out_packer #(
  parameter int FIFO_DEPTH  = 16,
  parameter int FULL_MARGIN = 4
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [7:0]  din,
  input  logic        din_valid,
  output logic        full,
  output logic [31:0] m_data,
  output logic [3:0]  m_keep,
  output logic        m_last,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] frame_cnt,
  output logic        overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_W = PTR_W - 1;
  localparam logic [PTR_W-1:0] DEPTH_C    = PTR_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] MARGIN_C   = PTR_W'(FULL_MARGIN);
  localparam logic [PTR_W-1:0] LAST_PTR_C = PTR_W'(FIFO_DEPTH - 1);

  // Lanes occupied once the byte at position idx has been written.
  function automatic logic [3:0] keep_for_idx(input logic [1:0] idx);
    case (idx)
      2'd0:    return 4'b1000;
      2'd1:    return 4'b1100;
      2'd2:    return 4'b1110;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_place(input logic [7:0] b, input logic [1:0] idx);
    case (idx)
      2'd0:    return {b, 24'h000000};
      2'd1:    return {8'h00, b, 16'h0000};
      2'd2:    return {16'h0000, b, 8'h00};
      default: return {24'h000000, b};
    endcase
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR_C) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  logic [1:0]       byte_idx_r;
  logic             prev_ff_r;
  logic [31:0]      word_r;
  logic [31:0]      word_s;
  logic [3:0]       push_keep_s;
  logic             eoi_s;
  logic             push_s;

  logic [31:0]      data_mem_r [FIFO_DEPTH];
  logic [3:0]       keep_mem_r [FIFO_DEPTH];
  logic             last_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] count_r;
  logic [PTR_W-1:0] count_next_s;
  logic [PTR_W-1:0] free_next_s;
  logic             valid_r;
  logic             full_r;
  logic             overflow_r;
  logic [15:0]      frame_cnt_r;
  logic             pop_s;
  logic             wr_en_s;
  logic             drop_s;

  // Word assembly and end-of-frame decode for the incoming byte.
  always_comb begin
    word_s      = word_r | lane_place(din, byte_idx_r);
    push_keep_s = keep_for_idx(byte_idx_r);
    eoi_s       = 1'b0;
    push_s      = 1'b0;
    if (din_valid) begin
      eoi_s  = prev_ff_r && (din == 8'hD9);
      push_s = eoi_s || (byte_idx_r == 2'd3);
    end else begin
      eoi_s  = 1'b0;
      push_s = 1'b0;
    end
  end

  // Byte position, partial word and FF-prefix tracking; idle cycles hold state.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      byte_idx_r <= 2'd0;
      prev_ff_r  <= 1'b0;
      word_r     <= 32'h00000000;
    end else if (din_valid) begin
      prev_ff_r <= (din == 8'hFF);
      if (push_s) begin
        byte_idx_r <= 2'd0;
        word_r     <= 32'h00000000;
      end else begin
        byte_idx_r <= byte_idx_r + 2'd1;
        word_r     <= word_s;
      end
    end
  end

  // A pop frees the head slot in the same edge, so a push into a full FIFO is kept then.
  always_comb begin
    pop_s        = valid_r && m_ready;
    wr_en_s      = push_s && ((count_r != DEPTH_C) || pop_s);
    drop_s       = push_s && (count_r == DEPTH_C) && !pop_s;
    count_next_s = count_r;
    case ({wr_en_s, pop_s})
      2'b10:   count_next_s = count_r + PTR_W'(1);
      2'b01:   count_next_s = count_r - PTR_W'(1);
      default: count_next_s = count_r;
    endcase
    free_next_s = DEPTH_C - count_next_s;
  end

  // FIFO storage; emptiness is governed by the pointers, so entries need no reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      data_mem_r[wr_ptr_r[IDX_W-1:0]] <= word_s;
      keep_mem_r[wr_ptr_r[IDX_W-1:0]] <= push_keep_s;
      last_mem_r[wr_ptr_r[IDX_W-1:0]] <= eoi_s;
    end
  end

  // FIFO pointers, occupancy and status registers.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {PTR_W{1'b0}};
      valid_r     <= 1'b0;
      full_r      <= 1'b0;
      overflow_r  <= 1'b0;
      frame_cnt_r <= 16'd0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      if (pop_s && m_last) begin
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end
      count_r <= count_next_s;
      valid_r <= (count_next_s != {PTR_W{1'b0}});
      full_r  <= (free_next_s <= MARGIN_C);
    end
  end

  // Head entry drives the stream; lanes read as zero while the FIFO is empty.
  always_comb begin
    if (valid_r) begin
      m_data = data_mem_r[rd_ptr_r[IDX_W-1:0]];
      m_keep = keep_mem_r[rd_ptr_r[IDX_W-1:0]];
      m_last = last_mem_r[rd_ptr_r[IDX_W-1:0]];
    end else begin
      m_data = 32'h00000000;
      m_keep = 4'b0000;
      m_last = 1'b0;
    end
  end

  assign m_valid   = valid_r;
  assign full      = full_r;
  assign overflow  = overflow_r;
  assign frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_jpeg_out_packer.sv
// Self-checking bench for jpeg_out_packer: byte-vector table plus FIFO corner sequences,
// with a scoreboard queue of expected words compared as the DUT hands them off.
module tb_jpeg_out_packer;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        nrst;
  logic [7:0]  din;
  logic        din_valid;
  logic        full;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_last;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] frame_cnt;
  logic        overflow;

  jpeg_out_packer #(.FIFO_DEPTH(DEPTH), .FULL_MARGIN(4)) dut (
    .clk(clk), .nrst(nrst), .din(din), .din_valid(din_valid), .full(full),
    .m_data(m_data), .m_keep(m_keep), .m_last(m_last), .m_valid(m_valid),
    .m_ready(m_ready), .frame_cnt(frame_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    logic [3:0]  k;
    logic        l;
  } exp_t;

  typedef struct {
    logic        vld;
    logic [7:0]  b;
    logic        push;
    logic [31:0] w;
    logic [3:0]  k;
    logic        l;
  } vec_t;

  exp_t exp_q[$];
  exp_t e;
  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_frames = 0;
  logic exp_ovf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, req);
    end
  endtask

  // Scoreboard: every cycle the DUT shows a word it must equal the oldest expected one.
  always @(negedge clk) begin
    if (nrst === 1'b1 && m_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word got %h keep %h last %b", m_data, m_keep, m_last);
      end else begin
        e = exp_q[0];
        if ({m_data, m_keep, m_last} !== {e.w, e.k, e.l}) begin
          errors++;
          $display("FAIL word got %h/%h/%b expected %h/%h/%b",
                   m_data, m_keep, m_last, e.w, e.k, e.l);
        end
        if (m_ready) begin
          void'(exp_q.pop_front());
          if (e.l) exp_frames++;
        end
      end
    end
  end

  // Drive one cycle; an expected push is queued unless the model FIFO is full with no pop.
  task automatic send_byte(input logic vld, input logic [7:0] b, input logic rdy,
                           input logic push, input logic [31:0] w, input logic [3:0] k,
                           input logic l);
    exp_t x;
    din       = b;
    din_valid = vld;
    m_ready   = rdy;
    if (push) begin
      if (exp_q.size() >= DEPTH && !rdy) begin
        exp_ovf = 1'b1;
      end else begin
        x.w = w; x.k = k; x.l = l;
        exp_q.push_back(x);
      end
    end
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic rdy_last);
    send_byte(1'b1, w[31:24], 1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
    send_byte(1'b1, w[23:16], 1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
    send_byte(1'b1, w[15:8],  1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
    send_byte(1'b1, w[7:0],   rdy_last, 1'b1, w, 4'hF, 1'b0);
  endtask

  task automatic drain();
    int n;
    m_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 64) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout left %0d expected 0", exp_q.size());
    end
    chk("drained_m_valid", {31'd0, m_valid}, 32'd0);
  endtask

  task automatic add(input logic vld, input logic [7:0] b, input logic push,
                     input logic [31:0] w, input logic [3:0] k, input logic l);
    vec_t v;
    v.vld = vld; v.b = b; v.push = push; v.w = w; v.k = k; v.l = l;
    tbl.push_back(v);
  endtask

  function automatic logic [31:0] bulk_word(input int i);
    return {8'h30, 8'(i), 8'h5A, 8'hC3};
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    nrst = 1'b0; din = 8'h00; din_valid = 1'b0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid",   {31'd0, m_valid},   32'd0);
    chk("rst_m_data",    m_data,             32'd0);
    chk("rst_m_keep",    {28'd0, m_keep},    32'd0);
    chk("rst_m_last",    {31'd0, m_last},    32'd0);
    chk("rst_full",      {31'd0, full},      32'd0);
    chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    chk("rst_overflow",  {31'd0, overflow},  32'd0);
    nrst = 1'b1;

    // Byte stream vectors: packing, EOI at each lane, EOI across words, stuffing, gap.
    add(1, 8'h01, 0, 32'h0, 4'h0, 0); add(1, 8'h02, 0, 32'h0, 4'h0, 0);
    add(1, 8'h03, 0, 32'h0, 4'h0, 0); add(1, 8'h04, 1, 32'h01020304, 4'hF, 0);
    add(1, 8'h05, 0, 32'h0, 4'h0, 0); add(1, 8'h06, 0, 32'h0, 4'h0, 0);
    add(1, 8'h07, 0, 32'h0, 4'h0, 0); add(1, 8'h08, 1, 32'h05060708, 4'hF, 0);
    add(1, 8'h11, 0, 32'h0, 4'h0, 0); add(0, 8'hFF, 0, 32'h0, 4'h0, 0);
    add(1, 8'h22, 0, 32'h0, 4'h0, 0); add(1, 8'hFF, 0, 32'h0, 4'h0, 0);
    add(1, 8'hD9, 1, 32'h1122FFD9, 4'hF, 1);
    add(1, 8'hAA, 0, 32'h0, 4'h0, 0); add(1, 8'hFF, 0, 32'h0, 4'h0, 0);
    add(1, 8'hD9, 1, 32'hAAFFD900, 4'hE, 1);
    add(1, 8'h01, 0, 32'h0, 4'h0, 0); add(1, 8'h02, 0, 32'h0, 4'h0, 0);
    add(1, 8'h03, 0, 32'h0, 4'h0, 0); add(1, 8'hFF, 1, 32'h010203FF, 4'hF, 0);
    add(1, 8'hD9, 1, 32'hD9000000, 4'h8, 1);
    add(1, 8'hFF, 0, 32'h0, 4'h0, 0); add(1, 8'h00, 0, 32'h0, 4'h0, 0);
    add(1, 8'hD9, 0, 32'h0, 4'h0, 0); add(1, 8'h55, 1, 32'hFF00D955, 4'hF, 0);
    add(1, 8'h77, 0, 32'h0, 4'h0, 0); add(1, 8'hFF, 0, 32'h0, 4'h0, 0);
    add(1, 8'hFF, 0, 32'h0, 4'h0, 0); add(1, 8'hD9, 1, 32'h77FFFFD9, 4'hF, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      send_byte(tbl[i].vld, tbl[i].b, 1'b1, tbl[i].push, tbl[i].w, tbl[i].k, tbl[i].l);
      chk($sformatf("latency_valid_%0d", i), {31'd0, m_valid}, {31'd0, tbl[i].push});
    end
    drain();
    chk("frame_cnt_table", {16'd0, frame_cnt}, 32'd4);
    chk("frame_cnt_model", {16'd0, frame_cnt}, 32'(exp_frames));

    // Backpressure: full rises with the 12th buffered word, falls after the first pop.
    for (int i = 0; i < 12; i++) begin
      send_word(bulk_word(i), 1'b0);
      if (i == 10) chk("full_at_11", {31'd0, full}, 32'd0);
    end
    chk("full_at_12", {31'd0, full}, 32'd1);
    chk("ovf_at_12",  {31'd0, overflow}, 32'd0);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("full_after_pop", {31'd0, full}, 32'd0);
    drain();

    // Overflow: the 17th word is dropped; then a push and pop together at count 16.
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_word(bulk_word(i + 16), 1'b0);
    chk("ovf_at_16", {31'd0, overflow}, 32'd0);
    send_word(bulk_word(32), 1'b0);
    chk("ovf_at_17", {31'd0, overflow}, {31'd0, exp_ovf});
    send_word(bulk_word(33), 1'b1);
    m_ready = 1'b0;
    chk("full_pushpop", {31'd0, full}, 32'd1);
    chk("ovf_sticky",   {31'd0, overflow}, 32'd1);
    drain();
    chk("full_drained", {31'd0, full}, 32'd0);

    // Reset mid-frame with words buffered discards everything.
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_word(bulk_word(i + 40), 1'b0);
    send_byte(1'b1, 8'h61, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
    send_byte(1'b1, 8'h62, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
    nrst = 1'b0;
    exp_q.delete();
    exp_frames = 0;
    exp_ovf = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_m_valid",   {31'd0, m_valid},   32'd0);
    chk("mid_rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    chk("mid_rst_overflow",  {31'd0, overflow},  32'd0);
    chk("mid_rst_full",      {31'd0, full},      32'd0);
    nrst = 1'b1;
    send_byte(1'b1, 8'h0A, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
    send_byte(1'b1, 8'h0B, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
    send_byte(1'b1, 8'h0C, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
    send_byte(1'b1, 8'h0D, 1'b1, 1'b1, 32'h0A0B0C0D, 4'hF, 1'b0);
    chk("post_rst_valid", {31'd0, m_valid}, 32'd1);
    drain();
    chk("post_rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
